// File: rtl/lsu_pkg.sv
// Shared encodings and helpers for the byte-serial load/store unit.
package lsu_pkg;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ACCESS = 2'b01,
        DONE   = 2'b10
    } lsu_state_e;

    // Number of bytes moved by an access of the given size.
    function automatic logic [3:0] bytes_of(input logic [1:0] size);
        bytes_of = 4'd1 << size;
    endfunction

    function automatic logic [7:0] byte_sel(input logic [63:0] data, input logic [2:0] idx);
        byte_sel = data[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Request/response handshake between the MEM stage and the load/store unit.
interface load_store_unit_if #(
    parameter int ADDR_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [63:0]       req_wdata;
    logic              resp_valid;
    logic              resp_err;
    logic [63:0]       resp_rdata;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_err, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, resp_valid, resp_err, resp_rdata
    );
endinterface

// File: rtl/load_extend.sv
// Sign/zero extension of an assembled little-endian load value to 64 bits.
module load_extend
    import lsu_pkg::*;
(
    input  logic [63:0] raw,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [63:0] ext
);

    // Replicate or clear the bits above the loaded width.
    always_comb begin
        ext = raw;
        case (size)
            SZ_B:    ext = is_unsigned ? {56'd0, raw[7:0]}  : {{56{raw[7]}},  raw[7:0]};
            SZ_H:    ext = is_unsigned ? {48'd0, raw[15:0]} : {{48{raw[15]}}, raw[15:0]};
            SZ_W:    ext = is_unsigned ? {32'd0, raw[31:0]} : {{32{raw[31]}}, raw[31:0]};
            SZ_D:    ext = raw;
            default: ext = raw;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Serializes one pipeline load/store into per-byte data memory accesses,
// little-endian, one byte per cycle, with alignment and range rejection.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 64,
    parameter int ADDR_W    = 64
)(
    input  logic              clk,
    input  logic              reset,
    load_store_unit_if.slave  bus,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [7:0]        mem_rdata
);

    localparam logic [ADDR_W:0] MEM_LIMIT = (ADDR_W+1)'(MEM_BYTES);

    lsu_state_e        state_r;
    logic [2:0]        idx_r;
    logic              write_r;
    logic [1:0]        size_r;
    logic              unsigned_r;
    logic [63:0]       wdata_r;
    logic [63:0]       asm_r;

    logic              ready_r;
    logic              resp_valid_r;
    logic              resp_err_r;
    logic [63:0]       resp_rdata_r;
    logic [ADDR_W-1:0] mem_addr_r;
    logic [7:0]        mem_wdata_r;
    logic              mem_we_r;
    logic              mem_re_r;

    logic [3:0]        n_s;
    logic [ADDR_W:0]   last_addr_s;
    logic              misalign_s;
    logic              out_of_range_s;
    logic              last_s;
    logic [2:0]        idx_next_s;
    logic [63:0]       asm_next_s;
    logic [63:0]       ext_s;

    // The last byte address is formed one bit wider so addresses near the top cannot wrap.
    assign n_s            = bytes_of(bus.req_size);
    assign last_addr_s    = {1'b0, bus.req_addr} + {{(ADDR_W-3){1'b0}}, n_s}
                          - {{ADDR_W{1'b0}}, 1'b1};
    assign misalign_s     = (bus.req_addr[2:0] & (n_s[2:0] - 3'd1)) != 3'd0;
    assign out_of_range_s = last_addr_s >= MEM_LIMIT;
    assign last_s         = ({1'b0, idx_r} == (bytes_of(size_r) - 4'd1));
    assign idx_next_s     = idx_r + 3'd1;

    // Merge the byte being read this cycle so the final byte is visible to the extender.
    always_comb begin
        asm_next_s = asm_r;
        if (state_r == ACCESS && !write_r) begin
            asm_next_s[{idx_r, 3'b000} +: 8] = mem_rdata;
        end else begin
            asm_next_s = asm_r;
        end
    end

    load_extend u_extend (
        .raw         (asm_next_s),
        .size        (size_r),
        .is_unsigned (unsigned_r),
        .ext         (ext_s)
    );

    // Request sequencer: all outputs are registered and driven from this block.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= IDLE;
            idx_r        <= 3'd0;
            write_r      <= 1'b0;
            size_r       <= 2'b00;
            unsigned_r   <= 1'b0;
            wdata_r      <= 64'd0;
            asm_r        <= 64'd0;
            ready_r      <= 1'b1;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 64'd0;
            mem_addr_r   <= {ADDR_W{1'b0}};
            mem_wdata_r  <= 8'd0;
            mem_we_r     <= 1'b0;
            mem_re_r     <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 64'd0;
                    if (bus.req_valid) begin
                        write_r    <= bus.req_write;
                        size_r     <= bus.req_size;
                        unsigned_r <= bus.req_unsigned;
                        wdata_r    <= bus.req_wdata;
                        asm_r      <= 64'd0;
                        idx_r      <= 3'd0;
                        ready_r    <= 1'b0;
                        mem_addr_r <= bus.req_addr;
                        if (misalign_s || out_of_range_s) begin
                            state_r      <= DONE;
                            resp_valid_r <= 1'b1;
                            resp_err_r   <= 1'b1;
                        end else begin
                            state_r     <= ACCESS;
                            mem_we_r    <= bus.req_write;
                            mem_re_r    <= !bus.req_write;
                            mem_wdata_r <= bus.req_write ? bus.req_wdata[7:0] : 8'd0;
                        end
                    end else begin
                        ready_r <= 1'b1;
                    end
                end
                ACCESS: begin
                    asm_r <= asm_next_s;
                    if (last_s) begin
                        state_r      <= DONE;
                        mem_we_r     <= 1'b0;
                        mem_re_r     <= 1'b0;
                        mem_addr_r   <= {ADDR_W{1'b0}};
                        mem_wdata_r  <= 8'd0;
                        resp_valid_r <= 1'b1;
                        resp_err_r   <= 1'b0;
                        resp_rdata_r <= write_r ? 64'd0 : ext_s;
                    end else begin
                        idx_r       <= idx_next_s;
                        mem_addr_r  <= mem_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
                        mem_wdata_r <= write_r ? byte_sel(wdata_r, idx_next_s) : 8'd0;
                    end
                end
                DONE: begin
                    state_r      <= IDLE;
                    idx_r        <= 3'd0;
                    ready_r      <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 64'd0;
                    mem_addr_r   <= {ADDR_W{1'b0}};
                end
                default: begin
                    state_r      <= IDLE;
                    idx_r        <= 3'd0;
                    ready_r      <= 1'b1;
                    resp_valid_r <= 1'b0;
                    resp_err_r   <= 1'b0;
                    resp_rdata_r <= 64'd0;
                    mem_addr_r   <= {ADDR_W{1'b0}};
                    mem_wdata_r  <= 8'd0;
                    mem_we_r     <= 1'b0;
                    mem_re_r     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.req_ready  = ready_r;
    assign bus.resp_valid = resp_valid_r;
    assign bus.resp_err   = resp_err_r;
    assign bus.resp_rdata = resp_rdata_r;
    assign mem_addr       = mem_addr_r;
    assign mem_wdata      = mem_wdata_r;
    assign mem_we         = mem_we_r;
    assign mem_re         = mem_re_r;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference memory predicts
// every response and every memory beat; a monitor compares as they appear.
module tb_load_store_unit;

    logic        clk;
    logic        reset;
    logic        preload;
    logic [63:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [7:0]  mem_rdata;
    logic [7:0]  dmem [64];
    logic [7:0]  ref_mem [64];

    load_store_unit_if #(.ADDR_W(64)) bus ();

    load_store_unit #(.MEM_BYTES(64), .ADDR_W(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic        err;
        logic        write;
        logic [63:0] rdata;
        logic [63:0] addr;
        logic [63:0] wdata;
        int          n;
        int          due;
    } exp_t;

    exp_t        exp_q [$];
    int          checks   = 0;
    int          errors   = 0;
    int          cyc      = 0;
    int          acc_cnt  = 0;
    int          last_acc = 0;
    int          act_cnt  = 0;
    logic [63:0] last_rdata = 64'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Data memory: writes on the rising edge, reads combinationally.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 64; i++) dmem[i] <= 8'(i * 37 + 5);
        end else if (mem_we && mem_addr < 64'd64) begin
            dmem[mem_addr[5:0]] <= mem_wdata;
        end
    end
    assign mem_rdata = (mem_addr < 64'd64) ? dmem[mem_addr[5:0]] : 8'h00;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Reference model: predicts each accepted request from the byte-array memory.
    initial begin
        exp_t        e;
        logic [63:0] v;
        forever begin
            @(posedge clk);
            if (!reset && bus.req_valid && bus.req_ready) begin
                e.n     = 1 << bus.req_size;
                e.write = bus.req_write;
                e.addr  = bus.req_addr;
                e.wdata = bus.req_wdata;
                e.err   = (bus.req_addr % 64'(e.n) != 64'd0) ||
                          ({1'b0, bus.req_addr} + 65'(e.n) > 65'd64);
                e.rdata = 64'd0;
                if (!e.err && e.write) begin
                    for (int i = 0; i < e.n; i++)
                        ref_mem[int'(bus.req_addr[5:0]) + i] = 8'(bus.req_wdata >> (8 * i));
                end else if (!e.err) begin
                    v = 64'd0;
                    for (int i = 0; i < e.n; i++)
                        v = v | (64'(ref_mem[int'(bus.req_addr[5:0]) + i]) << (8 * i));
                    if (e.n < 8 && !bus.req_unsigned && v[8 * e.n - 1])
                        v = v | (~64'd0 << (8 * e.n));
                    e.rdata = v;
                end
                e.due = cyc + (e.err ? 1 : e.n + 1);
                exp_q.push_back(e);
                acc_cnt++;
                last_acc = cyc;
            end
            cyc++;
        end
    end

    // Monitor: checks every memory beat and every response against the queue head.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset) begin
                act_cnt = 0;
            end else begin
                if (mem_we || mem_re) begin
                    if (exp_q.size() == 0) begin
                        check("mem_activity_when_idle", 64'(mem_we || mem_re), 64'd0);
                    end else begin
                        e = exp_q[0];
                        check("mem_on_error", 64'(e.err), 64'd0);
                        check("mem_we_re", {62'd0, mem_we, mem_re}, {62'd0, e.write, !e.write});
                        check("mem_addr", mem_addr, e.addr + 64'(act_cnt));
                        if (e.write) check("mem_wdata", 64'(mem_wdata), 64'(8'(e.wdata >> (8 * act_cnt))));
                        act_cnt++;
                    end
                end
                if (bus.resp_valid) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", 64'(bus.resp_valid), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_err", 64'(bus.resp_err), 64'(e.err));
                        check("resp_rdata", bus.resp_rdata, e.rdata);
                        check("resp_cycle", 64'(cyc), 64'(e.due));
                        check("beat_count", 64'(act_cnt), e.err ? 64'd0 : 64'(e.n));
                        last_rdata = bus.resp_rdata;
                    end
                    act_cnt = 0;
                end
            end
        end
    end

    task automatic issue(input logic w, input logic [1:0] sz, input logic u,
                         input logic [63:0] a, input logic [63:0] d);
        int base;
        base = acc_cnt;
        bus.req_write    = w;
        bus.req_size     = sz;
        bus.req_unsigned = u;
        bus.req_addr     = a;
        bus.req_wdata    = d;
        bus.req_valid    = 1'b1;
        for (int t = 0; t < 100 && acc_cnt == base; t++) @(negedge clk);
        if (acc_cnt == base) check("accept_timeout", 64'(acc_cnt - base), 64'd1);
        bus.req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || !bus.req_ready) && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("idle_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic run(input logic w, input logic [1:0] sz, input logic u,
                       input logic [63:0] a, input logic [63:0] d);
        issue(w, sz, u, a, d);
        wait_idle();
    endtask

    initial begin
        logic [7:0]  snap [5];
        logic [63:0] a;
        logic [63:0] sd_data;
        int          first_acc;
        int          base;
        int          sel;
        int          sz;

        reset            = 1'b1;
        preload          = 1'b1;
        bus.req_valid    = 1'b0;
        bus.req_write    = 1'b0;
        bus.req_size     = 2'b00;
        bus.req_unsigned = 1'b0;
        bus.req_addr     = 64'd0;
        bus.req_wdata    = 64'd0;
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i * 37 + 5);
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd1);
        check("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        check("rst_resp_err", 64'(bus.resp_err), 64'd0);
        check("rst_resp_rdata", bus.resp_rdata, 64'd0);
        check("rst_mem_strobes", {62'd0, mem_we, mem_re}, 64'd0);
        check("rst_mem_addr", mem_addr, 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        @(negedge clk);
        reset   = 1'b0;
        preload = 1'b0;
        @(negedge clk);

        // Store/load round trip with all extensions.
        run(1'b1, 2'b11, 1'b0, 64'd8, 64'h8000_0000_0000_00FF);
        check("sd_byte8", 64'(dmem[8]), 64'h FF);
        check("sd_byte15", 64'(dmem[15]), 64'h80);
        check("sd_rdata", last_rdata, 64'd0);
        run(1'b0, 2'b11, 1'b0, 64'd8, 64'd0);
        check("ld8", last_rdata, 64'h8000_0000_0000_00FF);
        run(1'b0, 2'b00, 1'b0, 64'd8, 64'd0);
        check("lb8", last_rdata, 64'hFFFF_FFFF_FFFF_FFFF);
        run(1'b0, 2'b00, 1'b1, 64'd8, 64'd0);
        check("lbu8", last_rdata, 64'h0000_0000_0000_00FF);
        run(1'b0, 2'b01, 1'b0, 64'd14, 64'd0);
        check("lh14", last_rdata, 64'hFFFF_FFFF_FFFF_8000);
        run(1'b0, 2'b10, 1'b1, 64'd12, 64'd0);
        check("lwu12", last_rdata, 64'h0000_0000_8000_0000);

        // Rejections and boundaries.
        run(1'b0, 2'b01, 1'b0, 64'd3, 64'd0);
        run(1'b0, 2'b11, 1'b0, 64'd60, 64'd0);
        run(1'b0, 2'b11, 1'b0, 64'd56, 64'd0);
        run(1'b0, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8, 64'd0);
        check("wrap_err_rdata", last_rdata, 64'd0);
        run(1'b1, 2'b00, 1'b0, 64'd63, 64'h0000_0000_0000_005A);
        check("sb63", 64'(dmem[63]), 64'h5A);

        // Reset in the fourth beat of a store.
        for (int i = 0; i < 5; i++) snap[i] = ref_mem[19 + i];
        sd_data = 64'h1122_3344_5566_7788;
        issue(1'b1, 2'b11, 1'b0, 64'd16, sd_data);
        repeat (3) @(negedge clk);
        check("pre_reset_we", 64'(mem_we), 64'd1);
        reset = 1'b1;
        #1;
        check("reset_we_drop", 64'(mem_we), 64'd0);
        check("reset_ready", 64'(bus.req_ready), 64'd1);
        exp_q.delete();
        for (int i = 0; i < 5; i++) ref_mem[19 + i] = snap[i];
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) check("partial_written", 64'(dmem[16 + i]), 64'(8'(sd_data >> (8 * i))));
        for (int i = 0; i < 5; i++) check("partial_untouched", 64'(dmem[19 + i]), 64'(snap[i]));
        run(1'b0, 2'b11, 1'b0, 64'd16, 64'd0);

        // Request held valid with changing fields while the unit is busy.
        base = acc_cnt;
        bus.req_write = 1'b0; bus.req_size = 2'b11; bus.req_unsigned = 1'b0;
        bus.req_addr = 64'd56; bus.req_wdata = 64'd0; bus.req_valid = 1'b1;
        first_acc = -1;
        for (int t = 0; t < 60 && acc_cnt < base + 2; t++) begin
            @(negedge clk);
            if (acc_cnt == base + 1 && first_acc < 0) first_acc = last_acc;
            bus.req_addr  = 64'(8 * $urandom_range(0, 7));
            bus.req_wdata = {$urandom, $urandom};
        end
        bus.req_valid = 1'b0;
        check("held_accepts", 64'(acc_cnt - base), 64'd2);
        check("held_spacing", 64'(last_acc - first_acc), 64'd10);
        wait_idle();

        // Randomized traffic.
        for (int k = 0; k < 200; k++) begin
            sz  = $urandom_range(0, 3);
            sel = $urandom_range(0, 9);
            if (sel <= 6)      a = 64'($urandom_range(0, 63)) & ~(64'(1 << sz) - 64'd1);
            else if (sel == 7) a = 64'($urandom_range(0, 63));
            else if (sel == 8) a = 64'($urandom_range(64, 80));
            else               a = {$urandom, $urandom} | 64'hFFFF_FFFF_0000_0000;
            run(($urandom_range(0, 9) < 4), 2'(sz), 1'($urandom_range(0, 1)), a, {$urandom, $urandom});
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
